code_serializer: RTL and testbench

Downstream stage of the digit-to-code converter. Captures each 5-bit code word (v,w,x,y,z) when the converter's ready strobe rises and buffers it in a small FIFO. Transmits each word on a single serial line as a framed, even-parity bit stream so that a display or remote board can consume the digit sequence without a 5-wire bus.

---
 rtl/code_serializer_pkg.sv | 22 ++
 rtl/code_fifo.sv | 66 ++++++
 rtl/code_serializer.sv | 158 +++++++++++++++
 tb/tb_code_serializer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/code_serializer_pkg.sv
// Shared constants, FSM encodings and helpers for the code serializer slice.
package code_serializer_pkg;

  localparam int FRAME_BITS = 8;
  localparam int DATA_BITS  = 5;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/code_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is accepted only when a pop
// happens on the same edge. Flags are registered and track post-edge occupancy.
module code_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1'b1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic [PTR_W:0]   count_next_s;
  logic             do_push_s;
  logic             do_pop_s;

  assign dout = mem_r[rd_ptr_r];

  // Qualify requests against occupancy and compute the next count.
  always_comb begin
    do_pop_s     = pop && (count_r != '0);
    do_push_s    = push && ((count_r != FULL_CNT) || do_pop_s);
    count_next_s = count_r;
    case ({do_push_s, do_pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Pointers, occupancy and registered flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      count_r <= count_next_s;
      empty   <= (count_next_s == '0);
      full    <= (count_next_s == FULL_CNT);
    end
  end

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= din;
  end

endmodule

// File: rtl/code_serializer.sv
// Captures 5-bit code words on the rising edge of ready, buffers them, and
// sends each as an 8-bit frame: start, v..z, even parity, stop.
module code_serializer
  import code_serializer_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int BIT_CYCLES = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ready,
  input  logic             in_v,
  input  logic             in_w,
  input  logic             in_x,
  input  logic             in_y,
  input  logic             in_z,
  output logic             tx,
  output logic             busy,
  output logic             fifo_empty,
  output logic             fifo_full,
  output logic             overflow,
  output logic [CNT_W-1:0] frames_sent
);

  localparam int TIMER_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(BIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1'b1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1'b1);
  localparam logic [2:0]         LAST_BIT   = 3'(DATA_BITS - 1);

  logic                 ready_q_r;
  logic                 push_req_s;
  logic                 pop_s;
  logic [DATA_BITS-1:0] word_s;
  logic [DATA_BITS-1:0] fifo_dout_s;
  logic                 overflow_r;
  state_t               state_r;
  state_t               state_next_s;
  logic                 busy_r;
  logic [TIMER_W-1:0]   timer_r;
  logic                 timer_done_s;
  logic [2:0]           bit_idx_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 parity_r;
  logic [CNT_W-1:0]     frames_r;

  assign word_s       = {in_v, in_w, in_x, in_y, in_z};
  assign push_req_s   = ready && !ready_q_r;
  assign timer_done_s = (timer_r == '0);
  assign busy         = busy_r;
  assign overflow     = overflow_r;
  assign frames_sent  = frames_r;

  code_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(DATA_BITS)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push_req_s),
    .pop  (pop_s),
    .din  (word_s),
    .dout (fifo_dout_s),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  // Ready edge detector and sticky drop flag (a full FIFO without a same-edge pop drops).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q_r  <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      ready_q_r <= ready;
      if (push_req_s && fifo_full && !pop_s) overflow_r <= 1'b1;
    end
  end

  // Next-state and pop decision; a word is popped only from IDLE.
  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_next_s = ST_START;
          pop_s        = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (timer_done_s) state_next_s = ST_DATA;
        else              state_next_s = ST_START;
      end
      ST_DATA: begin
        if (timer_done_s && (bit_idx_r == LAST_BIT)) state_next_s = ST_PARITY;
        else                                         state_next_s = ST_DATA;
      end
      ST_PARITY: begin
        if (timer_done_s) state_next_s = ST_STOP;
        else              state_next_s = ST_PARITY;
      end
      ST_STOP: begin
        if (timer_done_s) state_next_s = ST_IDLE;
        else              state_next_s = ST_STOP;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Line level follows the state directly so reset forces it high without a clock.
  always_comb begin
    tx = STOP_LVL;
    case (state_r)
      ST_START:  tx = START_LVL;
      ST_DATA:   tx = shift_r[DATA_BITS-1];
      ST_PARITY: tx = parity_r;
      ST_STOP:   tx = STOP_LVL;
      default:   tx = STOP_LVL;
    endcase
  end

  // FSM state, bit timer, shift register and completed-frame counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      busy_r    <= 1'b0;
      timer_r   <= '0;
      bit_idx_r <= '0;
      shift_r   <= '0;
      parity_r  <= 1'b0;
      frames_r  <= '0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != ST_IDLE);
      if (pop_s) begin
        shift_r   <= fifo_dout_s;
        parity_r  <= even_parity(fifo_dout_s);
        timer_r   <= TIMER_LOAD;
        bit_idx_r <= '0;
      end else if (state_r != ST_IDLE) begin
        if (timer_done_s) begin
          timer_r <= TIMER_LOAD;
          if (state_r == ST_DATA) begin
            shift_r   <= {shift_r[DATA_BITS-2:0], 1'b0};
            bit_idx_r <= bit_idx_r + 3'd1;
          end
          if (state_r == ST_STOP) frames_r <= frames_r + CNT_ONE;
        end else begin
          timer_r <= timer_r - TIMER_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_code_serializer.sv
// Bench for code_serializer: instance A (BIT_CYCLES=4) runs the functional
// cases, instance B (BIT_CYCLES=1) runs the 256-frame counter wrap case.
module tb_code_serializer;

  localparam int BC_A = 4;
  localparam int BC_B = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       ready_a, ready_b;
  logic [4:0] word_a, word_b;
  logic       tx_a, busy_a, empty_a, full_a, ovf_a;
  logic       tx_b, busy_b, empty_b, full_b, ovf_b;
  logic [7:0] frames_a, frames_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] exp_q_a[$];
  logic [7:0] exp_q_b[$];

  typedef struct {
    logic [4:0] word;
    logic       par;
    logic       accept;
    logic       full;
    logic       ovf;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  code_serializer #(.DEPTH(4), .BIT_CYCLES(BC_A), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .ready(ready_a),
    .in_v(word_a[4]), .in_w(word_a[3]), .in_x(word_a[2]), .in_y(word_a[1]), .in_z(word_a[0]),
    .tx(tx_a), .busy(busy_a), .fifo_empty(empty_a), .fifo_full(full_a),
    .overflow(ovf_a), .frames_sent(frames_a)
  );

  code_serializer #(.DEPTH(4), .BIT_CYCLES(BC_B), .CNT_W(8)) dut_b (
    .clk(clk), .reset(reset), .ready(ready_b),
    .in_v(word_b[4]), .in_w(word_b[3]), .in_x(word_b[2]), .in_y(word_b[1]), .in_z(word_b[0]),
    .tx(tx_b), .busy(busy_b), .fifo_empty(empty_b), .fifo_full(full_b),
    .overflow(ovf_b), .frames_sent(frames_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [7:0] frame_of(input logic [4:0] w);
    return {1'b0, w, w[4] ^ w[3] ^ w[2] ^ w[1] ^ w[0], 1'b1};
  endfunction

  task automatic wait_idle_a(input int budget, input string tag);
    int n = 0;
    while ((busy_a || !empty_a) && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(busy_a || !empty_a), 32'd0);
  endtask

  task automatic pulse_a(input logic [4:0] w);
    word_a  = w;
    ready_a = 1'b1;
    exp_q_a.push_back(frame_of(w));
    tick();
    ready_a = 1'b0;
    tick();
  endtask

  // Frame monitor A: samples each bit cell, flags a level change inside a cell.
  int         a_pos = -1;
  logic [7:0] a_seq;
  logic       a_glitch;
  always @(negedge clk) begin
    if (reset) begin
      a_pos = -1;
    end else begin
      if (a_pos < 0 && tx_a == 1'b0) begin
        a_pos    = 0;
        a_glitch = 1'b0;
      end
      if (a_pos >= 0) begin
        if (a_pos % BC_A == 0) a_seq[7 - (a_pos / BC_A)] = tx_a;
        else if (tx_a !== a_seq[7 - (a_pos / BC_A)]) a_glitch = 1'b1;
        if (a_pos == 8 * BC_A - 1) begin
          check("frame_a_queued", 32'(exp_q_a.size() > 0), 32'd1);
          if (exp_q_a.size() > 0) check("frame_a", {23'd0, a_glitch, a_seq}, {24'd0, exp_q_a.pop_front()});
          a_pos = -1;
        end else begin
          a_pos++;
        end
      end
    end
  end

  // Frame monitor B: one cycle per bit, plus start-to-start spacing.
  int         b_pos = -1;
  int         b_nframes = 0;
  int         b_last_start = 0;
  logic [7:0] b_seq;
  always @(negedge clk) begin
    if (reset) begin
      b_pos = -1;
    end else begin
      if (b_pos < 0 && tx_b == 1'b0) begin
        if (b_nframes > 0) check("gap_b", 32'(cyc - b_last_start), 32'd9);
        b_last_start = cyc;
        b_nframes++;
        b_pos = 0;
      end
      if (b_pos >= 0) begin
        b_seq[7 - b_pos] = tx_b;
        if (b_pos == 7) begin
          check("frame_b_queued", 32'(exp_q_b.size() > 0), 32'd1);
          if (exp_q_b.size() > 0) check("frame_b", {24'd0, b_seq}, {24'd0, exp_q_b.pop_front()});
          b_pos = -1;
        end else begin
          b_pos++;
        end
      end
    end
  end

  initial begin
    int         n;
    int         busy_cnt;
    int         tx_low_cnt;
    int         sent;
    logic [7:0] prev;
    logic [7:0] nxt;
    logic       saw_wrap;

    vecs[0] = '{5'b00000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{5'b00001, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{5'b00010, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{5'b00011, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{5'b00100, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{5'b00101, 1'b0, 1'b0, 1'b1, 1'b1};

    reset = 1'b1; ready_a = 1'b0; ready_b = 1'b0; word_a = 5'd0; word_b = 5'd0;
    tick(); tick();
    check("rst_tx", 32'(tx_a), 32'd1);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_empty", 32'(empty_a), 32'd1);
    check("rst_full", 32'(full_a), 32'd0);
    check("rst_ovf", 32'(ovf_a), 32'd0);
    check("rst_frames", 32'(frames_a), 32'd0);
    check("rst_tx_b", 32'(tx_b), 32'd1);
    reset = 1'b0;
    tick();

    // Single word 10110: latency and 32-cycle frame.
    word_a = 5'b10110; ready_a = 1'b1;
    exp_q_a.push_back(8'b0101_1011);
    tick();
    check("t1_empty_n1", 32'(empty_a), 32'd0);
    check("t1_tx_n1", 32'(tx_a), 32'd1);
    ready_a = 1'b0;
    tick();
    check("t1_tx_n2", 32'(tx_a), 32'd0);
    check("t1_busy_n2", 32'(busy_a), 32'd1);
    check("t1_empty_n2", 32'(empty_a), 32'd1);
    busy_cnt = 1;
    n = 0;
    while (busy_a && n < 200) begin
      tick();
      n++;
      if (busy_a) busy_cnt++;
    end
    check("t1_busy_len", 32'(busy_cnt), 32'd32);
    check("t1_frames", 32'(frames_a), 32'd1);
    check("t1_empty_end", 32'(empty_a), 32'd1);
    check("t1_q", 32'(exp_q_a.size()), 32'd0);

    // Burst of six words, two cycles apart: fill, then drop.
    for (int i = 0; i < 6; i++) begin
      word_a = vecs[i].word; ready_a = 1'b1;
      if (vecs[i].accept) exp_q_a.push_back({1'b0, vecs[i].word, vecs[i].par, 1'b1});
      tick();
      check($sformatf("t2_full_%0d", i), 32'(full_a), 32'(vecs[i].full));
      check($sformatf("t2_ovf_%0d", i), 32'(ovf_a), 32'(vecs[i].ovf));
      ready_a = 1'b0;
      tick();
    end
    wait_idle_a(600, "t2_idle");
    check("t2_frames", 32'(frames_a), 32'd6);
    check("t2_ovf_end", 32'(ovf_a), 32'd1);
    check("t2_q", 32'(exp_q_a.size()), 32'd0);

    // Ready held high 20 cycles: exactly one frame.
    word_a = 5'b11111; ready_a = 1'b1;
    exp_q_a.push_back(8'b0111_1111);
    repeat (20) tick();
    ready_a = 1'b0;
    wait_idle_a(200, "t3_idle");
    repeat (10) tick();
    check("t3_frames", 32'(frames_a), 32'd7);
    check("t3_q", 32'(exp_q_a.size()), 32'd0);

    // Reset in the middle of the data bits.
    pulse_a(5'b01100); pulse_a(5'b00011); pulse_a(5'b11000);
    repeat (4) tick();
    check("t4_busy_pre", 32'(busy_a), 32'd1);
    reset = 1'b1;
    #1;
    check("t4_async_tx", 32'(tx_a), 32'd1);
    check("t4_async_busy", 32'(busy_a), 32'd0);
    check("t4_async_empty", 32'(empty_a), 32'd1);
    exp_q_a.delete();
    tick(); tick();
    reset = 1'b0;
    tick();
    check("t4_empty", 32'(empty_a), 32'd1);
    check("t4_frames", 32'(frames_a), 32'd0);
    check("t4_ovf", 32'(ovf_a), 32'd0);
    busy_cnt = 0; tx_low_cnt = 0;
    repeat (60) begin
      tick();
      if (busy_a) busy_cnt++;
      if (!tx_a) tx_low_cnt++;
    end
    check("t4_no_busy", 32'(busy_cnt), 32'd0);
    check("t4_no_tx", 32'(tx_low_cnt), 32'd0);

    // Full FIFO with a push on the very edge the FSM pops.
    pulse_a(5'b10001); pulse_a(5'b01010); pulse_a(5'b00111); pulse_a(5'b11100); pulse_a(5'b10101);
    check("t5_full", 32'(full_a), 32'd1);
    n = 0;
    while (busy_a && n < 100) begin
      tick();
      n++;
    end
    check("t5_reach_idle", 32'(busy_a), 32'd0);
    check("t5_full_idle", 32'(full_a), 32'd1);
    word_a = 5'b01101; ready_a = 1'b1;
    exp_q_a.push_back(frame_of(5'b01101));
    tick();
    ready_a = 1'b0;
    check("t5_full_after", 32'(full_a), 32'd1);
    check("t5_ovf_after", 32'(ovf_a), 32'd0);
    check("t5_busy_after", 32'(busy_a), 32'd1);
    wait_idle_a(1000, "t5_idle");
    check("t5_frames", 32'(frames_a), 32'd6);
    check("t5_ovf_end", 32'(ovf_a), 32'd0);
    check("t5_q", 32'(exp_q_a.size()), 32'd0);

    // 256 back-to-back frames at one cycle per bit: counter wraps.
    sent = 0; n = 0; saw_wrap = 1'b0;
    prev = frames_b;
    while ((sent < 256 || ready_b || busy_b || !empty_b) && n < 6000) begin
      if (ready_b) begin
        ready_b = 1'b0;
      end else if (sent < 256 && !full_b) begin
        word_b  = sent[4:0];
        ready_b = 1'b1;
        exp_q_b.push_back(frame_of(sent[4:0]));
        sent++;
      end
      tick();
      n++;
      if (frames_b !== prev) begin
        nxt = prev + 8'd1;
        check("t6_step", 32'(frames_b), 32'(nxt));
        if (prev == 8'd255) saw_wrap = 1'b1;
        prev = frames_b;
      end
    end
    check("t6_done", 32'(n < 6000), 32'd1);
    tick();
    check("t6_wrap", 32'(saw_wrap), 32'd1);
    check("t6_frames", 32'(frames_b), 32'd0);
    check("t6_ovf", 32'(ovf_b), 32'd0);
    check("t6_q", 32'(exp_q_b.size()), 32'd0);
    check("t6_count", 32'(b_nframes), 32'd256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
